// File: rtl/seq_controller.sv
// Instruction sequencer: fetch/wait/exec/done cycle with a store handshake and a halt trap.
// All outputs, including the one-hot state code, come straight from registers.
module seq_controller #(
    parameter int CNT_W    = 4,
    parameter int BR_LIMIT = 1,
    parameter int ACK_TO   = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       com,
    input  logic [CNT_W-1:0] counter_out,
    input  logic             mem_ack,
    output logic             memreg_set,
    output logic             memreg_reset,
    output logic             counter_set,
    output logic             counter_reset,
    output logic             memin,
    output logic             next,
    output logic             set,
    output logic             halted,
    output logic             err,
    output logic [7:0]       cur_state
);

    typedef enum logic [7:0] {
        S_IDLE  = 8'h01,
        S_FETCH = 8'h02,
        S_WAIT  = 8'h04,
        S_EXEC  = 8'h08,
        S_DONE  = 8'h10,
        S_WACK  = 8'h20,
        S_HALT  = 8'h40
    } state_e;

    localparam logic [2:0] OP_INIT  = 3'd0;
    localparam logic [2:0] OP_STEP  = 3'd1;
    localparam logic [2:0] OP_BRNE  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_JMP   = 3'd4;
    localparam logic [2:0] OP_HALT  = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    localparam logic [CNT_W-1:0] BR_CMP   = CNT_W'(BR_LIMIT);
    localparam logic [7:0]       TMO_INIT = 8'(ACK_TO);

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       took_q, took_d;
    logic [7:0] tmo_q, tmo_d;
    logic       ms_q, ms_d, mr_q, mr_d, cs_q, cs_d, cr_q, cr_d;
    logic       memin_q, memin_d, next_q, next_d, set_q, set_d;
    logic       halted_q, halted_d, err_q, err_d;

    // Strobes are decided one edge early so they are registered while the state they belong to is shown.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        took_d   = took_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        ms_d     = 1'b0;
        mr_d     = 1'b0;
        cs_d     = 1'b0;
        cr_d     = 1'b0;
        memin_d  = 1'b0;
        set_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_EXEC;
                op_d    = com;
                took_d  = 1'b0;
                case (com)
                    OP_INIT: begin
                        cr_d = 1'b1;
                        mr_d = 1'b1;
                    end
                    OP_STEP: begin
                        cs_d = 1'b1;
                        ms_d = 1'b1;
                    end
                    OP_BRNE: begin
                        set_d  = (counter_out != BR_CMP);
                        took_d = set_d;
                    end
                    OP_JMP: begin
                        set_d  = 1'b1;
                        took_d = 1'b1;
                    end
                    OP_ILL:  err_d = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_STORE: begin
                        state_d = S_WACK;
                        memin_d = 1'b1;
                        tmo_d   = TMO_INIT;
                    end
                    OP_HALT, OP_ILL: state_d = S_HALT;
                    default:         state_d = S_DONE;
                endcase
            end
            S_DONE: state_d = took_q ? S_WAIT : S_FETCH;
            S_WACK: begin
                if (mem_ack) begin
                    state_d = S_FETCH;
                end else if (tmo_q == 8'd0) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    tmo_d   = tmo_q - 8'd1;
                    memin_d = 1'b1;
                end
            end
            S_HALT:  ;
            default: state_d = S_IDLE;
        endcase
        next_d   = (state_d == S_FETCH);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            took_q   <= 1'b0;
            tmo_q    <= 8'd0;
            ms_q     <= 1'b0;
            mr_q     <= 1'b0;
            cs_q     <= 1'b0;
            cr_q     <= 1'b0;
            memin_q  <= 1'b0;
            next_q   <= 1'b0;
            set_q    <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            took_q   <= took_d;
            tmo_q    <= tmo_d;
            ms_q     <= ms_d;
            mr_q     <= mr_d;
            cs_q     <= cs_d;
            cr_q     <= cr_d;
            memin_q  <= memin_d;
            next_q   <= next_d;
            set_q    <= set_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign memreg_set    = ms_q;
    assign memreg_reset  = mr_q;
    assign counter_set   = cs_q;
    assign counter_reset = cr_q;
    assign memin         = memin_q;
    assign next          = next_q;
    assign set           = set_q;
    assign halted        = halted_q;
    assign err           = err_q;
    assign cur_state     = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: opcode vector table, multi-cycle handshake sequences,
// and random instruction streams checked against an instruction-level trace model.
module tb_seq_controller;

    localparam int ACK_TO = 15;

    localparam logic [7:0] S_IDLE  = 8'h01;
    localparam logic [7:0] S_FETCH = 8'h02;
    localparam logic [7:0] S_WAIT  = 8'h04;
    localparam logic [7:0] S_EXEC  = 8'h08;
    localparam logic [7:0] S_DONE  = 8'h10;
    localparam logic [7:0] S_WACK  = 8'h20;
    localparam logic [7:0] S_HALT  = 8'h40;

    localparam logic [8:0] F_MS  = 9'h100;
    localparam logic [8:0] F_MR  = 9'h080;
    localparam logic [8:0] F_CS  = 9'h040;
    localparam logic [8:0] F_CR  = 9'h020;
    localparam logic [8:0] F_MEM = 9'h010;
    localparam logic [8:0] F_NXT = 9'h008;
    localparam logic [8:0] F_SET = 9'h004;
    localparam logic [8:0] F_HLT = 9'h002;
    localparam logic [8:0] F_ERR = 9'h001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] com = 3'd0;
    logic [3:0] counter_out = 4'd0;
    logic [7:0] cnt_b = 8'd0;
    logic       mem_ack = 1'b0;

    logic ms_a, mr_a, cs_a, cr_a, memin_a, next_a, set_a, halted_a, err_a;
    logic [7:0] st_a;
    logic ms_b, mr_b, cs_b, cr_b, memin_b, next_b, set_b, halted_b, err_b;
    logic [7:0] st_b;

    int n_tests = 0;
    int n_fail  = 0;

    seq_controller #(.CNT_W(4), .BR_LIMIT(1), .ACK_TO(ACK_TO)) dut_a (
        .clock(clock), .reset(reset), .start(start), .com(com),
        .counter_out(counter_out), .mem_ack(mem_ack),
        .memreg_set(ms_a), .memreg_reset(mr_a), .counter_set(cs_a),
        .counter_reset(cr_a), .memin(memin_a), .next(next_a), .set(set_a),
        .halted(halted_a), .err(err_a), .cur_state(st_a)
    );

    seq_controller #(.CNT_W(8), .BR_LIMIT(0), .ACK_TO(ACK_TO)) dut_b (
        .clock(clock), .reset(reset), .start(start), .com(com),
        .counter_out(cnt_b), .mem_ack(mem_ack),
        .memreg_set(ms_b), .memreg_reset(mr_b), .counter_set(cs_b),
        .counter_reset(cr_b), .memin(memin_b), .next(next_b), .set(set_b),
        .halted(halted_b), .err(err_b), .cur_state(st_b)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  cnt;
        logic [8:0]  exec_f;
        logic [16:0] w4;
        logic [16:0] w5;
    } vec_t;

    function automatic logic [16:0] mk(input logic [7:0] s, input logic [8:0] f);
        return {s, f};
    endfunction

    function automatic logic [16:0] snap_a();
        return {st_a, ms_a, mr_a, cs_a, cr_a, memin_a, next_a, set_a, halted_a, err_a};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        mem_ack = 1'b0;
        com = 3'd0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Ends at the negedge of the EXEC cycle.
    task automatic go_exec(input logic [2:0] op, input logic [3:0] cnt);
        start = 1'b1;
        com = op;
        counter_out = cnt;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    // Expected per-cycle trace of one instruction, derived from the instruction rules.
    task automatic run_instr(input logic [2:0] op, input logic [3:0] cnt, input int dly,
                             inout bit ff, inout bit hlt);
        logic [16:0] ew[$];
        bit          av[$];
        bit          taken;
        logic [8:0]  ef;
        taken = (op == 3'd4) || (op == 3'd2 && cnt != 4'd1);
        if (ff) begin
            ew.push_back(mk(S_FETCH, F_NXT));
            av.push_back(1'($urandom));
        end
        ew.push_back(mk(S_WAIT, 9'h0));
        av.push_back(1'($urandom));
        case (op)
            3'd0:    ef = F_CR | F_MR;
            3'd1:    ef = F_CS | F_MS;
            3'd2:    ef = taken ? F_SET : 9'h0;
            3'd4:    ef = F_SET;
            3'd7:    ef = F_ERR;
            default: ef = 9'h0;
        endcase
        ew.push_back(mk(S_EXEC, ef));
        av.push_back(1'($urandom));
        if (op == 3'd3) begin
            if (dly <= ACK_TO) begin
                for (int j = 0; j <= dly; j++) begin
                    ew.push_back(mk(S_WACK, F_MEM));
                    av.push_back(j == dly);
                end
                ff = 1'b1;
            end else begin
                for (int j = 0; j <= ACK_TO; j++) begin
                    ew.push_back(mk(S_WACK, F_MEM));
                    av.push_back(1'b0);
                end
                for (int j = 0; j < 3; j++) begin
                    ew.push_back(mk(S_HALT, F_HLT | F_ERR));
                    av.push_back(1'($urandom));
                end
                hlt = 1'b1;
            end
        end else if (op == 3'd6 || op == 3'd7) begin
            for (int j = 0; j < 3; j++) begin
                ew.push_back(mk(S_HALT, F_HLT | ((op == 3'd7) ? F_ERR : 9'h0)));
                av.push_back(1'($urandom));
            end
            hlt = 1'b1;
        end else begin
            ew.push_back(mk(S_DONE, 9'h0));
            av.push_back(1'($urandom));
            ff = !taken;
        end
        for (int i = 0; i < ew.size(); i++) begin
            @(negedge clock);
            check($sformatf("rand op%0d cyc%0d", op, i), 32'(snap_a()), 32'(ew[i]));
            start = 1'($urandom);
            com = (hlt && i > 2) ? 3'($urandom) : op;
            counter_out = cnt;
            mem_ack = av[i];
        end
    endtask

    task automatic run_program(input int n_instr);
        bit ff;
        bit hlt;
        logic [2:0] op;
        logic [3:0] cnt;
        int r;
        do_reset();
        check("rand reset idle", 32'(snap_a()), 32'(mk(S_IDLE, 9'h0)));
        start = 1'b1;
        ff = 1'b1;
        hlt = 1'b0;
        for (int k = 0; k < n_instr && !hlt; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3) op = 3'd6;
            else if (r < 6) op = 3'd7;
            else op = 3'($urandom_range(0, 5));
            cnt = ($urandom_range(0, 1) == 1) ? 4'd1 : 4'($urandom_range(0, 15));
            run_instr(op, cnt, $urandom_range(0, 17), ff, hlt);
        end
    endtask

    vec_t vt[10];
    int   n;

    initial begin
        vt[0] = '{3'd0, 4'd0, F_CR | F_MR, mk(S_DONE, 9'h0), mk(S_FETCH, F_NXT)};
        vt[1] = '{3'd1, 4'd0, F_CS | F_MS, mk(S_DONE, 9'h0), mk(S_FETCH, F_NXT)};
        vt[2] = '{3'd2, 4'd3, F_SET, mk(S_DONE, 9'h0), mk(S_WAIT, 9'h0)};
        vt[3] = '{3'd2, 4'd1, 9'h0, mk(S_DONE, 9'h0), mk(S_FETCH, F_NXT)};
        vt[4] = '{3'd2, 4'd0, F_SET, mk(S_DONE, 9'h0), mk(S_WAIT, 9'h0)};
        vt[5] = '{3'd3, 4'd0, 9'h0, mk(S_WACK, F_MEM), mk(S_WACK, F_MEM)};
        vt[6] = '{3'd4, 4'd5, F_SET, mk(S_DONE, 9'h0), mk(S_WAIT, 9'h0)};
        vt[7] = '{3'd5, 4'd0, 9'h0, mk(S_DONE, 9'h0), mk(S_FETCH, F_NXT)};
        vt[8] = '{3'd6, 4'd0, 9'h0, mk(S_HALT, F_HLT), mk(S_HALT, F_HLT)};
        vt[9] = '{3'd7, 4'd0, F_ERR, mk(S_HALT, F_HLT | F_ERR), mk(S_HALT, F_HLT | F_ERR)};

        for (int v = 0; v < 10; v++) begin
            do_reset();
            check($sformatf("vec%0d idle", v), 32'(snap_a()), 32'(mk(S_IDLE, 9'h0)));
            start = 1'b1;
            com = vt[v].op;
            counter_out = vt[v].cnt;
            mem_ack = 1'b0;
            @(negedge clock);
            start = 1'b0;
            check($sformatf("vec%0d fetch", v), 32'(snap_a()), 32'(mk(S_FETCH, F_NXT)));
            @(negedge clock);
            check($sformatf("vec%0d wait", v), 32'(snap_a()), 32'(mk(S_WAIT, 9'h0)));
            @(negedge clock);
            check($sformatf("vec%0d exec", v), 32'(snap_a()), 32'(mk(S_EXEC, vt[v].exec_f)));
            @(negedge clock);
            check($sformatf("vec%0d cyc4", v), 32'(snap_a()), 32'(vt[v].w4));
            @(negedge clock);
            check($sformatf("vec%0d cyc5", v), 32'(snap_a()), 32'(vt[v].w5));
        end

        // Store acknowledged on the fourth WACK cycle.
        do_reset();
        go_exec(3'd3, 4'd0);
        @(negedge clock);
        n = 0;
        while (memin_a && n < 40) begin
            n++;
            mem_ack = (n == 4);
            @(negedge clock);
        end
        mem_ack = 1'b0;
        check("store ack memin cycles", 32'(n), 32'd4);
        check("store ack state", 32'(st_a), 32'(S_FETCH));
        check("store ack next", 32'(next_a), 32'd1);
        check("store ack err", 32'(err_a), 32'd0);

        // Store never acknowledged.
        do_reset();
        go_exec(3'd3, 4'd0);
        @(negedge clock);
        n = 0;
        while (memin_a && n < 40) begin
            n++;
            @(negedge clock);
        end
        check("store timeout memin cycles", 32'(n), 32'(ACK_TO + 1));
        check("store timeout err", 32'(err_a), 32'd1);
        check("store timeout halted", 32'(halted_a), 32'd1);
        check("store timeout state", 32'(st_a), 32'(S_HALT));

        // Illegal opcode traps; start is then ignored until reset.
        do_reset();
        go_exec(3'd7, 4'd0);
        check("ill exec err", 32'(err_a), 32'd1);
        @(negedge clock);
        start = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("ill halt hold%0d", i), 32'(snap_a()), 32'(mk(S_HALT, F_HLT | F_ERR)));
        end
        do_reset();
        check("ill reset recover", 32'(snap_a()), 32'(mk(S_IDLE, 9'h0)));

        // Reset mid-WACK on both parameterisations, with competing inputs asserted.
        do_reset();
        cnt_b = 8'd0;
        go_exec(3'd3, 4'd0);
        @(negedge clock);
        check("wack a memin", 32'({st_a, memin_a}), 32'({S_WACK, 1'b1}));
        check("wack b memin", 32'({st_b, memin_b}), 32'({S_WACK, 1'b1}));
        reset = 1'b1;
        start = 1'b1;
        mem_ack = 1'b1;
        com = 3'd7;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        mem_ack = 1'b0;
        check("wack reset a", 32'(snap_a()), 32'(mk(S_IDLE, 9'h0)));
        check("wack reset b", 32'({st_b, memin_b, err_b, halted_b}), 32'({S_IDLE, 3'b000}));

        // Full-width branch compare on the 8-bit instance.
        do_reset();
        cnt_b = 8'd0;
        go_exec(3'd2, 4'd1);
        check("b brne eq limit", 32'(set_b), 32'd0);
        do_reset();
        cnt_b = 8'h80;
        go_exec(3'd2, 4'd1);
        check("b brne high bit", 32'(set_b), 32'd1);
        @(negedge clock);
        @(negedge clock);
        check("b brne taken state", 32'({st_b, next_b}), 32'({S_WAIT, 1'b0}));

        for (int p = 0; p < 40; p++) run_program(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
